// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded instruction fields into words and streams them into imem
// A small FIFO decouples the field handshake from imem write stalls.

module instr_encoder_loader #(
   parameter int          ADDR_W     = 9,
   parameter int          FIFO_DEPTH = 4,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [3:0]        in_dtype,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [11:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_stall,
   output logic              busy,
   output logic              done,
   output logic              overflow_err,
   output logic [ADDR_W:0]   instr_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0]        OP_ST     = 4'h6;
   localparam logic [3:0]        OP_HALT   = 4'hF;
   localparam logic [31:0]       HALT_WORD = 32'hF000_0000;
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

   logic [1:0]        state_q, state_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ovf_q, ovf_d;

   logic [31:0] fifo_mem_q [FIFO_DEPTH];

   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic        ovf_hit;
   logic [31:0] head_word;
   logic [31:0] enc_word;

   function automatic logic [31:0] encode(
      input logic [3:0]  op,
      input logic [3:0]  dt,
      input logic [3:0]  rd,
      input logic [3:0]  rs1,
      input logic [3:0]  rs2,
      input logic [11:0] imm
   );
      logic [31:0] w;
      if (op == OP_HALT) begin
         w = HALT_WORD;
      end else if (op == OP_ST) begin
         w = {op, dt, 4'h0, rs1, rs2, imm};
      end else begin
         w = {op, dt, rd, rs1, rs2, imm};
      end
      return w;
   endfunction

   assign fifo_empty = (rd_ptr_q == wr_ptr_q);
   assign fifo_full  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                       (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);
   assign head_word  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign enc_word   = encode(in_opcode, in_dtype, in_rd, in_rs1, in_rs2, in_imm);

   assign in_ready = (state_q == S_LOAD) && !fifo_full;
   assign push     = in_valid && in_ready;
   assign pop      = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty && !imem_stall;
   // Only HALT words carry opcode F, so the head opcode tells a clean finish from exhaustion.
   assign ovf_hit  = pop && (head_word[31:28] != OP_HALT) && (waddr_q == LAST_ADDR);

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      waddr_d  = waddr_q;
      count_d  = count_q;
      we_d     = pop;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ovf_d    = ovf_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         addr_d   = waddr_q;
         wdata_d  = head_word;
         count_d  = count_q + CNT_ONE;
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (waddr_q != LAST_ADDR) begin
            waddr_d = waddr_q + ADDR_ONE;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_LOAD;
               waddr_d  = BASE;
               count_d  = '0;
               ovf_d    = 1'b0;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
            end
         end
         S_LOAD: begin
            if (push && (in_opcode == OP_HALT)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fifo_empty) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The last non-HALT write still goes out; everything queued behind it is discarded.
      if (ovf_hit) begin
         ovf_d    = 1'b1;
         state_d  = S_DONE;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         waddr_q  <= BASE;
         count_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= BASE;
         wdata_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         waddr_q  <= waddr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign busy         = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign overflow_err = ovf_q;
   assign instr_count  = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized scoreboard bench for instr_encoder_loader
// Driver pushes expected writes from a session-level model; a monitor pops them on each imem write.

module tb_instr_encoder_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int BASE  = 0;
   localparam int LAST  = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_opcode = '0;
   logic [3:0]    in_dtype = '0;
   logic [3:0]    in_rd = '0;
   logic [3:0]    in_rs1 = '0;
   logic [3:0]    in_rs2 = '0;
   logic [11:0]   in_imm = '0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          imem_stall = 1'b0;
   logic          busy;
   logic          done;
   logic          overflow_err;
   logic [AW:0]   instr_count;

   instr_encoder_loader #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_dtype(in_dtype), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_stall(imem_stall), .busy(busy), .done(done),
      .overflow_err(overflow_err), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int stall_mode = 0;

   typedef struct {
      int          addr;
      logic [31:0] word;
   } wr_t;
   wr_t exp_q[$];

   int m_addr;
   int m_count;
   bit m_ovf;
   bit m_ended;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] expected_word(input int op, input int dt, input int rd,
                                                 input int rs1, input int rs2, input int imm);
      longint w;
      if (op == 15) return 32'hF000_0000;
      w = longint'(op) * (1 << 28) + longint'(dt) * (1 << 24)
        + longint'((op == 6) ? 0 : rd) * (1 << 20)
        + longint'(rs1) * (1 << 16) + longint'(rs2) * (1 << 12) + longint'(imm);
      return 32'(w);
   endfunction

   function automatic void model_start();
      m_addr  = BASE;
      m_count = 0;
      m_ovf   = 1'b0;
      m_ended = 1'b0;
   endfunction

   function automatic void model_accept(input int op, input int dt, input int rd,
                                        input int rs1, input int rs2, input int imm);
      wr_t e;
      if (m_ended) return;
      e.addr = m_addr;
      e.word = expected_word(op, dt, rd, rs1, rs2, imm);
      exp_q.push_back(e);
      m_count++;
      if (op != 15 && m_addr == LAST) begin
         m_ovf   = 1'b1;
         m_ended = 1'b1;
      end else if (op == 15) begin
         m_ended = 1'b1;
      end else begin
         m_addr++;
      end
   endfunction

   // Fields are scrambled on cycles where in_ready is low; none of that may be captured.
   task automatic send(input logic [3:0] op, input logic [3:0] dt, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [11:0] imm,
                       input int max_wait, output bit ok);
      bit rdy;
      ok = 1'b0;
      for (int i = 0; i < max_wait && !ok; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         #1;
         rdy = in_ready;
         if (rdy) begin
            in_opcode = op; in_dtype = dt; in_rd = rd;
            in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
         end else begin
            in_opcode = 4'($urandom); in_dtype = 4'($urandom); in_rd = 4'($urandom);
            in_rs1 = 4'($urandom); in_rs2 = 4'($urandom); in_imm = 12'($urandom);
         end
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            model_accept(int'(op), int'(dt), int'(rd), int'(rs1), int'(rs2), int'(imm));
         end
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic send_rand(input int max_wait, output bit ok);
      send(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 12'($urandom), max_wait, ok);
   endtask

   task automatic send_halt(input int max_wait, output bit ok);
      send(4'hF, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 12'($urandom),
           max_wait, ok);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_start();
      pulse_start();
      model_start();
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({name, "_done_reached"}, 64'(seen), 64'd1);
      @(negedge clk);
      chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_busy"}, 64'(busy), 64'd0);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({name, "_overflow_err"}, 64'(overflow_err), 64'(m_ovf));
      chk({name, "_instr_count"}, 64'(instr_count), 64'(m_count));
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_imem_we"}, 64'(imem_we), 64'd0);
      chk({name, "_imem_addr"}, 64'(imem_addr), 64'(BASE));
      chk({name, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({name, "_busy"}, 64'(busy), 64'd0);
      chk({name, "_done"}, 64'(done), 64'd0);
      chk({name, "_overflow_err"}, 64'(overflow_err), 64'd0);
      chk({name, "_instr_count"}, 64'(instr_count), 64'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         imem_stall = (stall_mode == 1) || ((stall_mode == 2) && ($urandom_range(0, 2) == 0));
      end
   end

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_write: got write 0x%0h @0x%0h, expected no write",
                        imem_wdata, imem_addr);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", 64'(imem_addr), 64'(e.addr));
               chk("write_data", 64'(imem_wdata), 64'(e.word));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int n;
      model_start();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Basic session with latency check
      stall_mode = 0;
      do_start();
      chk("session_busy", 64'(busy), 64'd1);
      send(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 12'hABC, 10, ok);
      chk("basic_accept", 64'(ok), 64'd1);
      @(negedge clk);
      chk("latency_early_we", 64'(imem_we), 64'd0);
      @(negedge clk);
      chk("latency_we", 64'(imem_we), 64'd1);
      chk("latency_data", 64'(imem_wdata), 64'h1234_5ABC);
      send(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 10, ok);
      wait_done("basic");
      chk("basic_done", 64'(done), 64'd1);

      // ST rd forcing and HALT with nonzero fields
      do_start();
      send(4'h6, 4'h0, 4'h7, 4'h1, 4'h2, 12'h000, 10, ok);
      send(4'hF, 4'h3, 4'h4, 4'h5, 4'h6, 12'h123, 10, ok);
      wait_done("st_halt");

      // Stall fills the FIFO
      stall_mode = 1;
      do_start();
      for (int i = 0; i < DEPTH; i++) begin
         send_rand(5, ok);
         chk("stall_accept", 64'(ok), 64'd1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("stall_full_ready", 64'(in_ready), 64'd0);
         chk("stall_no_write", 64'(imem_we), 64'd0);
      end
      chk("stall_count", 64'(instr_count), 64'd0);
      stall_mode = 0;
      send_rand(10, ok);
      chk("stall_fifth_accept", 64'(ok), 64'd1);
      send_halt(10, ok);
      wait_done("stall");

      // Imem exhaustion
      stall_mode = 2;
      do_start();
      for (int i = 0; i < LAST + 10; i++) begin
         send_rand(20, ok);
         if (!ok) break;
      end
      wait_done("overflow");
      chk("overflow_flag", 64'(overflow_err), 64'd1);
      chk("overflow_count", 64'(instr_count), 64'(LAST + 1));
      do_start();
      chk("restart_ovf_clear", 64'(overflow_err), 64'd0);
      chk("restart_done_clear", 64'(done), 64'd0);
      send_rand(20, ok);
      send_halt(20, ok);
      wait_done("after_overflow");

      // Reset with words buffered
      stall_mode = 1;
      do_start();
      send_rand(5, ok);
      send_rand(5, ok);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      exp_q.delete();
      model_start();
      stall_mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("postreset_busy", 64'(busy), 64'd0);
      chk("postreset_count", 64'(instr_count), 64'd0);

      // start during DRAIN is ignored
      stall_mode = 1;
      do_start();
      for (int i = 0; i < DEPTH - 1; i++) send_rand(5, ok);
      send_halt(5, ok);
      chk("drain_halt_accept", 64'(ok), 64'd1);
      pulse_start();
      chk("drain_busy", 64'(busy), 64'd1);
      stall_mode = 0;
      wait_done("drain_start");
      do_start();
      send_rand(10, ok);
      send_halt(10, ok);
      wait_done("restart");

      // Randomized sessions
      for (int s = 0; s < 10; s++) begin
         stall_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
         do_start();
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_rand(30, ok);
            chk("rand_accept", 64'(ok), 64'd1);
         end
         send_halt(30, ok);
         chk("rand_halt_accept", 64'(ok), 64'd1);
         wait_done("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit instruction words.
- Buffers the packed words in a small FIFO and streams them into instruction memory at consecutive addresses.
- Used by the host/test loader to build GPU programs in imem before kernel launch.
- A load session ends on HALT, or with an error if imem is exhausted.

Parameters:
- ADDR_W, 9, imem word-address width; last address is 2^ADDR_W-1.
- FIFO_DEPTH, 4, encode-to-write buffer entries; power of 2, at least 2.
- BASE_ADDR, 0, first imem address written by each session.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; opens a load session
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder accepts bundle this cycle
- in_opcode  input  4  opcode
- in_dtype  input  4  data type
- in_rd  input  4  destination register
- in_rs1  input  4  source register 1
- in_rs2  input  4  source register 2
- in_imm  input  12  immediate, packed in word bits [11:0]
- imem_we  output  1  imem write strobe
- imem_addr  output  ADDR_W  imem write address
- imem_wdata  output  32  packed instruction word
- imem_stall  input  1  imem cannot accept a write this cycle
- busy  output  1  session in progress (LOAD or DRAIN)
- done  output  1  session finished; held until next start
- overflow_err  output  1  imem exhausted before HALT; held until next start
- instr_count  output  ADDR_W+1  words written this session

Behaviour:
- Encoding: word = {opcode, dtype, rd, rs1, rs2, imm} at bits [31:28], [27:24], [23:20], [19:16], [15:12], [11:0].
- ST (opcode 6): rd field forced to 0.
- HALT (opcode F): word forced to 0xF0000000.
- Other opcodes pass all fields through unchanged.
- Reset: state IDLE; FIFO empty; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; in_ready=0; busy=0; done=0; overflow_err=0; instr_count=0.
- Reset asserted mid-session aborts the session and discards the FIFO contents. No partial write is issued after reset.
- Handshake: transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD) && FIFO not full.
  - Fields are sampled only on transfer.
  - in_valid may be held with changing fields while in_ready=0; nothing is captured.
- FSM IDLE:
  - start -> LOAD.
  - On entry to LOAD: write pointer = BASE_ADDR, instr_count=0, done=0, overflow_err=0.
- FSM LOAD:
  - Accepts bundles.
  - Transfer of a HALT bundle -> DRAIN; in_ready drops the next cycle.
- FSM DRAIN: accepts nothing; -> DONE when the FIFO is empty and the final write has been issued.
- FSM DONE:
  - done=1.
  - start -> LOAD, with the same entry actions as from IDLE.
- start is ignored in LOAD and DRAIN.
- Write side:
  - The FIFO head is popped when the FIFO is not empty, imem_stall=0, and the write side is not halted by error.
  - On pop: imem_we=1 next cycle; imem_addr = current pointer; imem_wdata = head word; pointer and instr_count increment.
  - imem_we=0 on cycles with no pop.
  - While imem_stall=1, imem_we is 0 and the FIFO holds.
- Latency: bundle accepted at edge N, FIFO empty, no stall -> imem_we=1 with that word during the cycle after edge N+1.
- Throughput: 1 word/cycle sustained with no stall.
- A push and a pop in the same cycle are both allowed. The FIFO never drops or duplicates entries.
- Overflow:
  - If a non-HALT word is written to address 2^ADDR_W-1, overflow_err=1, the FIFO is flushed, and the FSM goes to DONE.
  - HALT written to the last address is a clean finish.
  - The pointer never wraps.
- instr_count counts issued writes, including HALT.

Test Plan:
- Reset, start, push {op=1, dt=2, rd=3, rs1=4, rs2=5, imm=0xABC} then HALT -> writes 0x12345ABC @0 and 0xF0000000 @1; done=1; instr_count=2; busy falls.
- Push ST {op=6, dt=0, rd=7, rs1=1, rs2=2, imm=0} -> imem_wdata=0x60012000 (rd zeroed). Push HALT with nonzero fields -> 0xF0000000.
- Hold imem_stall=1 and push 5 bundles -> in_ready=0 after 4 accepts, no writes. Release stall -> 4 writes on consecutive cycles at addresses 0-3, then the 5th is accepted; order preserved.
- ADDR_W=2, push 5 non-HALT bundles -> writes @0..3, overflow_err=1 after the @3 write, done=1, 5th bundle never written. Next start clears both flags.
- Assert rst_n low mid-LOAD with 2 words buffered -> imem_we=0 immediately; all outputs return to reset values; no further writes until a new start.
- Pulse start during DRAIN -> ignored; session ends normally; start in DONE restarts at BASE_ADDR.
